// File: rtl/fpu_issue_sched.sv
// ============================================================================
// Module   : fpu_issue_sched
// Purpose  : FPU issue scheduler with FP register scoreboard, write-back
//            reservation shift register and single write-back slot driver.
//            Optional macro FPU_ISSUE_SCHED_BYPASS_EN: the write-back of this
//            cycle is treated as forwarded, so dependents may issue with it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_sched #(
  parameter int MAX_LAT = 8,
  parameter int LATW    = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic [LATW-1:0] issue_lat,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic            issue_src_fp_a,
  input  logic            issue_src_fp_b,
  input  logic            issue_wr_fp,
  output logic            stall,
  output logic            issue_fire,
  output logic            wb_valid,
  output logic            wb_fp,
  output logic [4:0]      wb_rd,
  output logic            busy,
  output logic [LATW-1:0] inflight
);

  logic [MAX_LAT-1:0] v_q, v_d;
  logic [MAX_LAT-1:0] fp_q, fp_d;
  logic [4:0]         rd_q [MAX_LAT];
  logic [4:0]         rd_d [MAX_LAT];
  logic [31:0]        pend_q, pend_d;

  logic [LATW-1:0]    lat_eff;
  logic [31:0]        pend_chk;
  logic               raw_a, raw_b, waw, struct_haz;
  logic [LATW-1:0]    cnt;

  assign wb_valid = v_q[0];
  assign wb_fp    = fp_q[0];
  assign wb_rd    = rd_q[0];

  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0)
      lat_eff = LATW'(1);
    else if (issue_lat > LATW'(MAX_LAT))
      lat_eff = LATW'(MAX_LAT);

    pend_chk = pend_q;
`ifdef FPU_ISSUE_SCHED_BYPASS_EN
    if (v_q[0] && fp_q[0])
      pend_chk[rd_q[0]] = 1'b0;
`endif

    raw_a = issue_src_fp_a & pend_chk[issue_rs1];
    raw_b = issue_src_fp_b & pend_chk[issue_rs2];
    waw   = issue_wr_fp & pend_chk[issue_rd];

    // An op of latency L completes from slot L-1 after this edge, so it
    // collides with whatever currently sits one slot higher.
    struct_haz = 1'b0;
    for (int i = 0; i < MAX_LAT; i++)
      if (LATW'(i) == lat_eff)
        struct_haz = struct_haz | v_q[i];

    stall      = issue_valid & (raw_a | raw_b | waw | struct_haz) & ~flush;
    issue_fire = issue_valid & ~stall & ~flush;
  end

  always_comb begin
    for (int i = 0; i < MAX_LAT - 1; i++) begin
      v_d[i]  = v_q[i+1];
      fp_d[i] = fp_q[i+1];
      rd_d[i] = rd_q[i+1];
    end
    v_d[MAX_LAT-1]  = 1'b0;
    fp_d[MAX_LAT-1] = 1'b0;
    rd_d[MAX_LAT-1] = 5'd0;

    if (issue_fire) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (LATW'(i + 1) == lat_eff) begin
          v_d[i]  = 1'b1;
          fp_d[i] = issue_wr_fp;
          rd_d[i] = issue_rd;
        end
      end
    end

    // Set after clear so a same-index re-allocation keeps the bit.
    pend_d = pend_q;
    if (v_q[0] && fp_q[0])
      pend_d[rd_q[0]] = 1'b0;
    if (issue_fire && issue_wr_fp)
      pend_d[issue_rd] = 1'b1;

    if (flush) begin
      v_d    = '0;
      fp_d   = '0;
      pend_d = '0;
      for (int i = 0; i < MAX_LAT; i++)
        rd_d[i] = 5'd0;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < MAX_LAT; i++)
      cnt = cnt + {{(LATW-1){1'b0}}, v_q[i]};
    inflight = cnt;
    busy     = |v_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      fp_q   <= '0;
      pend_q <= '0;
      for (int i = 0; i < MAX_LAT; i++)
        rd_q[i] <= 5'd0;
    end else begin
      v_q    <= v_d;
      fp_q   <= fp_d;
      pend_q <= pend_d;
      for (int i = 0; i < MAX_LAT; i++)
        rd_q[i] <= rd_d[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_sched.sv
// ============================================================================
// Module   : tb_fpu_issue_sched
// Purpose  : Self-checking bench for fpu_issue_sched against a queue-based
//            model of in-flight ops keyed by absolute completion cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_sched;

  localparam int MAX_LAT = 8;
  localparam int LATW    = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            issue_valid = 1'b0;
  logic [LATW-1:0] issue_lat = '0;
  logic [4:0]      issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic            issue_src_fp_a = 1'b0, issue_src_fp_b = 1'b0, issue_wr_fp = 1'b0;
  logic            stall, issue_fire, wb_valid, wb_fp, busy;
  logic [4:0]      wb_rd;
  logic [LATW-1:0] inflight;

  fpu_issue_sched #(.MAX_LAT(MAX_LAT), .LATW(LATW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_lat(issue_lat), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_src_fp_a(issue_src_fp_a), .issue_src_fp_b(issue_src_fp_b),
    .issue_wr_fp(issue_wr_fp),
    .stall(stall), .issue_fire(issue_fire), .wb_valid(wb_valid),
    .wb_fp(wb_fp), .wb_rd(wb_rd), .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    bit       fp;
    bit [4:0] rd;
  } op_t;

  op_t q[$];
  int  now = 0;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, now, got, exp);
    end
  endtask

  // A register is pending while any in-flight op (including the one
  // completing now) will write it; with forwarding the completing one is free.
  function automatic bit m_pend(bit [4:0] r);
    foreach (q[i]) begin
      if (q[i].fp && q[i].rd == r) begin
`ifdef FPU_ISSUE_SCHED_BYPASS_EN
        if (q[i].due != now) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_eff(int lat);
    if (lat == 0) return 1;
    if (lat > MAX_LAT) return MAX_LAT;
    return lat;
  endfunction

  function automatic bit m_busy_at(int due);
    foreach (q[i]) if (q[i].due == due) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle(input bit v, input int lat, input bit [4:0] rd,
                       input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit fa, input bit fb, input bit wf, input bit fl);
    int  le;
    bit  haz, e_stall, e_fire, e_wbv, e_wbf;
    bit [4:0] e_wbr;
    @(negedge clk);
    issue_valid = v; issue_lat = LATW'(lat); issue_rd = rd;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_src_fp_a = fa;
    issue_src_fp_b = fb; issue_wr_fp = wf; flush = fl;
    #1;
    le  = m_eff(lat);
    haz = (fa && m_pend(rs1)) || (fb && m_pend(rs2)) || (wf && m_pend(rd)) ||
          (le < MAX_LAT && m_busy_at(now + le));
    e_stall = v && haz && !fl;
    e_fire  = v && !e_stall && !fl;
    e_wbv = 1'b0; e_wbf = 1'b0; e_wbr = 5'd0;
    foreach (q[i]) if (q[i].due == now) begin
      e_wbv = 1'b1; e_wbf = q[i].fp; e_wbr = q[i].rd;
    end
    chk("stall", stall, e_stall);
    chk("issue_fire", issue_fire, e_fire);
    chk("wb_valid", wb_valid, e_wbv);
    chk("wb_fp", wb_fp, e_wbf);
    chk("wb_rd", wb_rd, e_wbr);
    chk("inflight", inflight, q.size());
    chk("busy", busy, q.size() != 0);
    @(posedge clk);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due <= now) q.delete(i);
    if (fl) q.delete();
    else if (e_fire) q.push_back('{now + le, wf, rd});
    now++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    issue_valid = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #1;
    q.delete();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_fp", wb_fp, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fire", issue_fire, 0);
    @(posedge clk);
    now++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Basic L=3 op, then RAW chain against a long op.
    cycle(1, 3, 5, 0, 0, 0, 0, 1, 0);
    idle(4);
    cycle(1, 4, 2, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 9, 2, 0, 1, 0, 1, 0);
    idle(3);

    // Slot collision: L=4 then L=3 contending for the same completion cycle.
    cycle(1, 4, 10, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 3, 11, 0, 0, 0, 0, 1, 0);
    idle(6);

    // Back-to-back independent L=2 ops, plus latency extremes.
    for (int i = 0; i < 8; i++) cycle(1, 2, 5'(16 + i), 0, 0, 0, 0, 1, 0);
    idle(3);
    cycle(1, 0, 3, 0, 0, 0, 0, 1, 0);
    idle(2);
    cycle(1, 15, 4, 0, 0, 0, 0, 0, 0);
    idle(9);

    // Flush with ops in flight and a stalled dependent op.
    cycle(1, 6, 7, 0, 0, 0, 0, 1, 0);
    cycle(1, 5, 8, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 12, 7, 8, 1, 1, 1, 0);
    cycle(1, 1, 12, 7, 8, 1, 1, 1, 1);
    cycle(1, 1, 12, 7, 8, 1, 1, 1, 0);
    idle(3);

    // Reset with ops in flight.
    cycle(1, 5, 13, 0, 0, 0, 0, 1, 0);
    cycle(1, 7, 14, 0, 0, 0, 0, 1, 0);
    do_reset();
    idle(9);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
